// File: rtl/bias_add_pkg.sv
// Shared widths, saturation limits and word types for the bias-add stage.
package bias_add_pkg;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_BIAS_WIDTH = 16;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_SHIFT      = 8;

    typedef logic signed [DEF_ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [DEF_BIAS_WIDTH-1:0] bias_t;
    typedef logic signed [DEF_OUT_WIDTH-1:0]  out_t;

    localparam out_t SAT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
    localparam out_t SAT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};
endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic shift + saturate to OUT_W bits.
// BIAS_ADD_RELU_EN: clamp negative results to zero after saturation.
module sat_shift
    import bias_add_pkg::*;
#(
    parameter int SUM_W = DEF_ACC_WIDTH + 1,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_WIDTH
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [OUT_W-1:0] res
);
    localparam logic signed [SUM_W-1:0] SMAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SMIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat;

    assign shifted = sum >>> SHIFT;

    always_comb begin
        if (shifted > SMAX)      sat = SMAX[OUT_W-1:0];
        else if (shifted < SMIN) sat = SMIN[OUT_W-1:0];
        else                     sat = shifted[OUT_W-1:0];
    end

`ifdef BIAS_ADD_RELU_EN
    assign res = sat[OUT_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif
endmodule

// File: rtl/bias_add_stage.sv
// Adds a per-channel ROM bias to each accumulator beat, rescales and saturates.
// Optional ReLU clamp selected by BIAS_ADD_RELU_EN (see sat_shift).
module bias_add_stage
    import bias_add_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int NUM_CH     = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_CH),
    parameter int SHIFT      = DEF_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACC_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [BIAS_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0] out_ch,
    output logic                  out_last,
    output logic                  len_err
);
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(NUM_CH - 1);

    logic [ADDR_WIDTH-1:0]   ch_idx;
    logic                    in_fire, out_fire, at_last;
    logic signed [SUM_W-1:0] sum;
    logic signed [OUT_WIDTH-1:0] res;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign rom_addr = ch_idx;
    assign at_last  = (ch_idx == LAST_CH);

    assign sum = $signed({in_data[ACC_WIDTH-1], in_data})
               + $signed({{(SUM_W-BIAS_WIDTH){rom_data[BIAS_WIDTH-1]}}, rom_data});

    sat_shift #(
        .SUM_W (SUM_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .sum (sum),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_idx    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            len_err   <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_ch    <= ch_idx;
            out_last  <= in_last;
            // Length error whenever the vector end disagrees with the channel count.
            if (in_last != at_last) len_err <= 1'b1;
            if (in_last || at_last) ch_idx <= '0;
            else                    ch_idx <= ch_idx + ADDR_WIDTH'(1);
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bias_add_stage.sv
// Randomized + directed bench for bias_add_stage against a queue-based reference model.
module tb_bias_add_stage;
    import bias_add_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, len_err;
    logic [3:0]  rom_addr, out_ch;
    logic [15:0] rom_data, out_data;
    logic [15:0] rom [16];

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    bias_add_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .len_err(len_err)
    );

    typedef struct packed { logic [15:0] d; logic [3:0] ch; logic last; } beat_t;
    beat_t      q[$];
    logic [3:0] m_ch;
    logic       m_err;
    int         total = 0, bad = 0;

    function automatic logic [15:0] ref_out(input logic [31:0] a, input logic [15:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        s = s >>> DEF_SHIFT;
        if (s > longint'(SAT_MAX)) s = longint'(SAT_MAX);
        else if (s < longint'(SAT_MIN)) s = longint'(SAT_MIN);
`ifdef BIAS_ADD_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model past the edge.
    task automatic cycle(output bit fired);
        bit fi, fo;
        beat_t nb;
        #1;
        chk("in_ready", in_ready, (q.size() == 0) || out_ready);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ch", out_ch, q[0].ch);
            chk("out_last", out_last, q[0].last);
        end
        chk("rom_addr", rom_addr, m_ch);
        chk("len_err", len_err, m_err);
        fi = in_valid && (q.size() == 0 || out_ready);
        fo = (q.size() != 0) && out_ready;
        nb = '{ref_out(in_data, rom[m_ch]), m_ch, in_last};
        @(posedge clk); #1;
        if (fo) void'(q.pop_front());
        if (fi) begin
            q.push_back(nb);
            if (in_last) begin
                if (m_ch != 4'd15) m_err = 1'b1;
                m_ch = 4'd0;
            end else begin
                if (m_ch == 4'd15) m_err = 1'b1;
                m_ch = m_ch + 4'd1;
            end
        end
        fired = fi;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit f;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        do begin cycle(f); n++; end while (!f && n < 50);
        if (!f) begin
            total++; bad++;
            $error("FAIL send_timeout observed=no_fire expected=fire");
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); m_ch = 4'd0; m_err = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_ch", out_ch, 4'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_rom_addr", rom_addr, 4'd0);
    endtask

    initial begin
        bit f;
        int vec;
        logic [3:0]  pat = 4'b1001;
        logic [15:0] e_min, e_neg, e_m1;
`ifdef BIAS_ADD_RELU_EN
        e_min = 16'h0000; e_neg = 16'h0000; e_m1 = 16'h0000;
`else
        e_min = 16'h8000; e_neg = 16'hFF00; e_m1 = 16'hFFFF;
`endif
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h0100; rom[1] = 16'h7FFF; rom[2] = 16'h8000; rom[3] = 16'h0; rom[4] = 16'h0;
        m_ch = 4'd0; m_err = 1'b0;
        do_reset();

        // Directed arithmetic on channels 0..4, then complete the vector.
        out_ready = 1'b1;
        send(32'h0000_1000, 1'b0); chk("t1_data", out_data, 16'h0011); chk("t1_ch", out_ch, 4'd0);
        send(32'h7FFF_FFF0, 1'b0); chk("sat_pos", out_data, 16'h7FFF);
        send(32'h8000_0000, 1'b0); chk("sat_neg", out_data, e_min);
        send(32'hFFFF_0000, 1'b0); chk("neg_shift", out_data, e_neg);
        send(32'hFFFF_FFFF, 1'b0); chk("floor_m1", out_data, e_m1);
        for (int c = 5; c < 16; c++) send($urandom, c == 15);
        chk("vec_ok_err", len_err, 1'b0);
        chk("vec_ok_addr", rom_addr, 4'd0);
        cycle(f);

        // Backpressure: out_ready pattern 1-0-0-1, bursty input, three full vectors.
        vec = 0;
        for (int c = 0; c < 400 && vec < 3; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = (m_ch == 4'd15);
            out_ready = pat[c % 4];
            cycle(f);
            if (f && in_last) vec++;
        end
        if (vec < 3) begin
            total++; bad++;
            $error("FAIL bp_timeout observed=%0d expected=3", vec);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(f); cycle(f);

        // Short vector: last on channel 5.
        for (int c = 0; c < 5; c++) send($urandom, 1'b0);
        send($urandom, 1'b1);
        chk("short_err", len_err, 1'b1);
        chk("short_addr", rom_addr, 4'd0);
        do_reset();

        // Long vector: 17 beats without last.
        for (int c = 0; c < 17; c++) send($urandom, 1'b0);
        chk("long_err", len_err, 1'b1);
        chk("long_addr", rom_addr, 4'd1);
        do_reset();

        // Reset mid-vector with a beat held at the output.
        for (int c = 0; c < 7; c++) send($urandom, 1'b0);
        chk("mid_addr", rom_addr, 4'd7);
        chk("mid_valid", out_valid, 1'b1);
        do_reset();
        send(32'h0000_2000, 1'b0);
        chk("post_rst_data", out_data, 16'h0021);
        chk("post_rst_ch", out_ch, 4'd0);

        // Random traffic with occasional early last.
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            in_last   = (m_ch == 4'd15) || ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle(f);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(f); cycle(f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bias_add_stage.md
Name: bias_add_stage

Overview:
Post-MAC stage that adds a per-channel bias to each accumulator result, then rescales and saturates it.
- Sits directly upstream of the quantized-bias ROM and drives its address; that ROM returns data combinationally in the same cycle.
- Consumes a valid/ready stream of signed accumulator values, one per output channel.
- Produces a valid/ready stream of saturated OUT_WIDTH activations for the next layer.

Parameters:
ACC_WIDTH, 32, signed accumulator input width
BIAS_WIDTH, 16, signed bias word width (matches ROM DATA_WIDTH)
OUT_WIDTH, 16, signed output width
NUM_CH, 16, channels per vector (matches ROM DATA_DEPTH)
ADDR_WIDTH, $clog2(NUM_CH), ROM address width
SHIFT, 8, arithmetic right shift applied after the bias add

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_data  in  ACC_WIDTH  signed accumulator value
in_last  in  1  last channel of the vector
rom_addr  out  ADDR_WIDTH  bias ROM address (equals current channel index)
rom_data  in  BIAS_WIDTH  bias word from the ROM, same cycle
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  OUT_WIDTH  signed result
out_ch  out  ADDR_WIDTH  channel index of out_data
out_last  out  1  last channel of the vector
len_err  out  1  sticky: vector length mismatch

Behaviour:
- Reset (rst_n=0 sampled on a clk edge):
  - ch_idx=0, out_valid=0, out_data=0, out_ch=0, out_last=0, len_err=0.
  - Reset overrides all other activity; an in-flight output beat is discarded.
- in_ready = !out_valid || out_ready (combinational).
- Handshake:
  - Input fires when in_valid && in_ready; output fires when out_valid && out_ready.
  - in_valid/in_data/in_last are never required to stay stable before in_ready is high.
- rom_addr = ch_idx (registered counter, driven combinationally to the ROM). rom_data is sampled in the same cycle the input fires.
- Arithmetic:
  - sum = sext(in_data, ACC_WIDTH+1) + sext(rom_data, ACC_WIDTH+1).
  - shifted = sum >>> SHIFT (arithmetic shift, floor toward -inf).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency: 1 cycle. Data fired at edge N is presented with out_valid=1 after edge N.
- Output register:
  - Loads on input fire.
  - Holds data/ch/last stable while out_valid && !out_ready.
  - Output fire with no input fire clears out_valid.
  - Output fire and input fire in the same cycle: register reloads and out_valid stays 1 (full throughput, one beat per cycle).
- Channel counter, on input fire:
  - in_last=1: ch_idx returns to 0.
  - else ch_idx == NUM_CH-1: wrap to 0 and set len_err.
  - else ch_idx increments.
- len_err:
  - Also set when in_last=1 while ch_idx != NUM_CH-1.
  - Cleared only by reset.
- No state change when the input does not fire; rom_addr stays stable during a stall.

Optional Feature:
BIAS_ADD_RELU_EN
- Defined: after saturation, negative results are replaced by 0, so out_data is always in [0, 2^(OUT_WIDTH-1)-1].
- Undefined: signed saturated result is passed through unchanged.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package bias_add_pkg holds:
  - ACC_WIDTH/BIAS_WIDTH/OUT_WIDTH/SHIFT defaults;
  - SAT_MAX and SAT_MIN constants;
  - typedefs acc_t, bias_t, out_t.
- One natural sub-module, sat_shift, is purely combinational:
  - shifts, saturates and applies the optional ReLU;
  - is instantiated once and can be unit-tested alone.
- The top module keeps the counter, output register and handshake.

Test Plan:
1. Basic add, NUM_CH=16, SHIFT=8: ROM[0]=0x0100, in_data=0x00001000 on ch 0 -> out_data=0x0011, out_ch=0, one cycle later.
2. Saturation: in_data=0x7FFFFFF0, ROM[ch]=0x7FFF -> out_data=0x7FFF. in_data=0x80000000, bias 0x8000 -> out_data=0x8000 (0x0000 with BIAS_ADD_RELU_EN).
3. Negative and floor: in_data=-65536, bias 0 -> 0xFF00. in_data=-1, bias 0 -> 0xFFFF (0 with ReLU).
4. Backpressure: 16-beat vector, out_ready toggled 1-0-0-1 -> no beat lost or duplicated, out_data stable while stalled, in_ready low only while out_valid && !out_ready.
5. Length check:
   - in_last on ch 15 -> next vector starts at rom_addr 0, len_err=0.
   - in_last on ch 5 -> ch_idx=0 and len_err=1.
   - 17 beats with no in_last -> wrap to ch 0 and len_err=1.
6. Reset mid-vector: rst_n=0 for one cycle at ch 7 with out_valid=1 -> out_valid=0, rom_addr=0, len_err=0 next cycle, and the next beat uses ROM[0].
